// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; done at cycle WIDTH+2 after start, no backpressure (start ignored unless IDLE).
// Signed operation is compiled in only when SEQ_DIVIDER_SIGNED_EN is defined; otherwise every operation is unsigned.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] qacc;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] dvd_orig;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sign_a, sign_b;
  logic neg_q, neg_r;

  always_comb begin
    sign_a = signed_op & dividend[WIDTH-1];
    sign_b = signed_op & divisor[WIDTH-1];
    mag_a  = sign_a ? -dividend : dividend;
    mag_b  = sign_b ? -divisor  : divisor;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= sign_a ^ sign_b;
      neg_r <= sign_a;
    end
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign mag_a = dividend;
  assign mag_b = divisor;
`endif

  // Partial remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
  assign shifted = {prem, qacc[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC) || (state == FIX);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      prem        <= '0;
      qacc        <= '0;
      dvs         <= '0;
      dvd_orig    <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            qacc     <= mag_a;
            dvs      <= mag_b;
            dvd_orig <= dividend;
            prem     <= '0;
            cnt      <= CW'(WIDTH - 1);
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (!trial[WIDTH]) begin
            prem <= trial[WIDTH-1:0];
            qacc <= {qacc[WIDTH-2:0], 1'b1};
          end else begin
            prem <= shifted[WIDTH-1:0];
            qacc <= {qacc[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          if (dvs == '0) begin
            quotient    <= '1;
            remainder   <= dvd_orig;
            div_by_zero <= 1'b1;
          end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            quotient    <= neg_q ? -qacc : qacc;
            remainder   <= neg_r ? -prem : prem;
`else
            quotient    <= qacc;
            remainder   <= prem;
`endif
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at start, compared at done, with cycle-exact busy/done timing.
module tb_seq_divider;
  localparam int W = 32;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         signed_op;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } res_t;

  res_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .signed_op  (signed_op),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic res_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    res_t e;
    e.q = q;
    e.r = r;
    e.z = z;
    return e;
  endfunction

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    if (b == '0) return mk('1, a, 1'b1);
    if (s && SGN) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return mk(32'h8000_0000, '0, 1'b0);
      return mk($signed(a) / $signed(b), $signed(a) % $signed(b), 1'b0);
    end
    return mk(a / b, a % b, 1'b0);
  endfunction

  // inj_cyc: cycle carrying an extra start with fresh operands; rst_cyc: cycle in which reset is pulsed.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input res_t exp, input int inj_cyc, input int rst_cyc);
    int   cyc;
    logic seen;
    res_t got;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b1; dividend = a; divisor = b; signed_op = s;
    cyc = 0;
    seen = 1'b0;
    @(negedge clk);
    check_val("busy_c0", busy, 0);
    check_val("done_c0", done, 0);
    while (!seen && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == inj_cyc);
      dividend = $urandom;
      divisor = $urandom;
      signed_op = ~s;
      if (cyc == rst_cyc) begin
        #1 rst = 1'b1;
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_quot", quotient, 0);
        check_val("rst_rem", remainder, 0);
        check_val("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        void'(sb_q.pop_front());
        repeat (40) begin
          @(negedge clk);
          if (done) seen = 1'b1;
        end
        check_val("no_done_after_rst", seen, 0);
        return;
      end
      @(negedge clk);
      check_val("busy", busy, (cyc >= 1 && cyc <= W + 1));
      if (done) begin
        seen = 1'b1;
        check_val("done_cycle", cyc, W + 2);
        got = sb_q.pop_front();
        check_val("quotient", quotient, got.q);
        check_val("remainder", remainder, got.r);
        check_val("div_by_zero", div_by_zero, got.z);
      end
    end
    check_val("done_seen", seen, 1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; signed_op = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    check_val("reset_quot", quotient, 0);
    check_val("reset_rem", remainder, 0);
    check_val("reset_dbz", div_by_zero, 0);

    run_op(32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2, 1'b0), -1, -1);
    if (SGN) run_op(32'hFFFF_FFF9, 32'd2, 1'b1, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0), -1, -1);
    else     run_op(32'hFFFF_FFF9, 32'd2, 1'b1, mk(32'h7FFF_FFFC, 32'd1, 1'b0), -1, -1);
    run_op(32'd5, 32'd0, 1'b0, mk(32'hFFFF_FFFF, 32'd5, 1'b1), -1, -1);
    run_op(32'd5, 32'd0, 1'b1, mk(32'hFFFF_FFFF, 32'd5, 1'b1), -1, -1);
    if (SGN) run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'h8000_0000, 32'd0, 1'b0), -1, -1);
    else     run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'd0, 32'h8000_0000, 1'b0), -1, -1);
    run_op(32'd1000, 32'd3, 1'b0, mk(32'd333, 32'd1, 1'b0), 10, -1);
    // Issued in the cycle right after DONE: accepted there, finishing 34 cycles later.
    run_op(32'd12345, 32'd100, 1'b0, mk(32'd123, 32'd45, 1'b0), -1, -1);
    run_op(32'hDEAD_BEEF, 32'd5, 1'b0, mk('0, '0, 1'b0), -1, 15);
    run_op(32'd9, 32'd3, 1'b0, mk(32'd3, 32'd0, 1'b0), -1, -1);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 4 == 1) rb = -rb;
      rs = 1'(i % 3 != 0);
      run_op(ra, rb, rs, model(ra, rb, rs), -1, -1);
    end

    check_val("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative restoring divider for the LABH1 datapath. It takes operands from the upstream operand `register` instances, computes quotient and remainder in one bit per cycle, and pulses `done` when finished. `done` drives the `en` input of the downstream result `register` instances, so those registers capture `quotient` and `remainder` in the same cycle that `done` is high.

## Interface
- `WIDTH`, default 32: operand and result width in bits; must be 2 or more.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: request a division; sampled only in IDLE.
- `dividend`  in  WIDTH: dividend, latched when `start` is accepted.
- `divisor`  in  WIDTH: divisor, latched when `start` is accepted.
- `signed_op`  in  1: 1 = two's-complement division, 0 = unsigned; latched with the operands.
- `busy`  out  1: high while in CALC or FIX.
- `done`  out  1: high for exactly one cycle, in state DONE.
- `quotient`  out  WIDTH: quotient result.
- `remainder`  out  WIDTH: remainder result.
- `div_by_zero`  out  1: set when the latched divisor was 0.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE to CALC when `start`=1.
  - Latch the operands and `signed_op`.
  - In signed mode, take the magnitudes of both operands and record the result signs.
  - Clear the partial remainder and load the iteration counter with WIDTH-1.
- CALC performs one restoring step per cycle:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude using a WIDTH+1-bit subtractor.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore.
- CALC to FIX when the counter reaches 0, after exactly WIDTH iterations.
- FIX applies the sign correction:
  - Negate the quotient when the operand signs differ.
  - Negate the remainder when the dividend is negative.
  - This truncates toward zero; the remainder takes the sign of the dividend.
- FIX to DONE unconditionally. DONE to IDLE unconditionally.
- Divisor = 0:
  - The operation runs the full latency.
  - FIX forces `quotient` to all ones and `remainder` to the original dividend, in both signed and unsigned modes.
  - `div_by_zero` is 1.
- Signed overflow (most negative value / -1): `quotient` is the most negative value, `remainder` = 0, `div_by_zero` = 0. This falls out of the magnitude path with no special case.
- `start` outside IDLE is ignored, including in the DONE cycle. Input operand changes after acceptance have no effect.
- `quotient`, `remainder` and `div_by_zero` update only in FIX. They hold their values until FIX of the next operation.

## Timing
- Call the cycle in which `start` is accepted cycle 0.
  - `busy`=1 in cycles 1 through WIDTH+1.
  - `done`=1 in cycle WIDTH+2 only; that is cycle 34 for WIDTH=32.
  - Results are valid from cycle WIDTH+2 onward.
- The earliest next `start` that can be accepted is in cycle WIDTH+3.
- Reset values: state IDLE; `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0.
- `rst` asserted at any point, including mid-CALC:
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - The in-flight operation is discarded and no `done` is produced.
  - The first `start` after `rst` deasserts is handled normally.

## Configuration
- `SEQ_DIVIDER_SIGNED_EN` defined:
  - `signed_op` is honoured.
  - The magnitude/negate logic and the FIX sign correction are compiled in.
- `SEQ_DIVIDER_SIGNED_EN` undefined:
  - `signed_op` is ignored and every operation is unsigned.
  - The sign logic is removed; FIX only applies the divide-by-zero override.
  - Latency is unchanged.

## Test plan
- Unsigned 100 / 7: `quotient`=14, `remainder`=2, `done` in cycle 34 only, `busy`=1 in cycles 1–33.
- Signed -7 / 2 (0xFFFFFFF9 / 2): `quotient`=0xFFFFFFFD, `remainder`=0xFFFFFFFF.
  - Without the macro, the same inputs give `quotient`=0x7FFFFFFC, `remainder`=1.
- 5 / 0, in both modes: `quotient`=0xFFFFFFFF, `remainder`=5, `div_by_zero`=1, `done` in cycle 34.
- Signed 0x80000000 / 0xFFFFFFFF: `quotient`=0x80000000, `remainder`=0, `div_by_zero`=0.
- Second `start` with new operands at cycle 10: ignored, and the first result is unchanged.
  - A `start` in cycle 35 is accepted, with `done` in cycle 69.
- `rst` pulsed at cycle 15 between clock edges: outputs go to 0 and state to IDLE before the next edge, and no `done` appears.
  - A subsequent 9 / 3 gives `quotient`=3, `remainder`=0.
